fc_result_streamer: RTL and testbench
=====================================

Name: fc_result_streamer

Overview:
Reads a completed FC-layer result vector back out of the output SRAM and presents it as a valid/ready beat stream to the next stage (activation/host DMA). It is the reader at the far end of the FC layer's output-SRAM write interface.
- start/finish control matches the FC layer.
- SRAM read latency is parameterised.
- Full-rate streaming under backpressure, with no lost or duplicated words.

Parameters:
ADDR_WIDTH, 16, SRAM address width
DATA_WIDTH, 32, result word width (signed)
RD_LATENCY, 1, SRAM read latency in cycles from addr/rden to valid rdata; legal range 1..3

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  one-cycle pulse; sampled only in IDLE
finish  output  1  one-cycle done pulse
length  input  8  number of words to stream (FC_OUT); sampled with start
base_addr  input  ADDR_WIDTH  first SRAM address; sampled with start
relu_en  input  1  1 = clamp negative words to 0; sampled with start
sram_result_rden  output  1  read enable to output SRAM
sram_result_addr  output  ADDR_WIDTH  read address
sram_result_rdata  input  DATA_WIDTH  signed read data, valid RD_LATENCY cycles after rden
m_valid  output  1  stream beat valid
m_ready  input  1  downstream accepts beat
m_data  output  DATA_WIDTH  signed beat data
m_last  output  1  high on final beat

Behaviour:
- Reset (rst=0, async) clears all state, the FIFO and in-flight tracking.
  - All outputs are 0 and FSM=IDLE.
  - This applies mid-stream: partial transfers are abandoned and no finish pulse is emitted.
- FSM states:
  - IDLE: start=1 latches length, base_addr and relu_en. length=0 goes to FINISH; otherwise goes to RUN.
  - RUN: issues reads and drains beats. Leaves for FINISH on the clock edge where the beat with m_last is handshaken (m_valid&m_ready).
  - FINISH: one cycle, then IDLE.
  - start is ignored outside IDLE.
- finish is registered and is high exactly while state==FINISH, i.e. one cycle.
- Read issue: rden=1 with addr=base_addr+issue_idx (modulo 2^ADDR_WIDTH wrap) when all of these hold:
  - issue_idx<length;
  - fifo_count+inflight < DEPTH, where DEPTH=RD_LATENCY+2.
  - rden/addr are combinational from registered state; addr=0 when rden=0.
- inflight is a RD_LATENCY-deep shift pipe of rden. Where it pops, sram_result_rdata is pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- FIFO is show-ahead:
  - m_valid = FIFO non-empty; m_data = head word.
  - relu_en applied on push: negative (MSB=1) becomes 0.
  - m_last = head is word length-1 (tracked by a beat counter).
- Handshake rules:
  - Once m_valid is asserted, m_valid, m_data and m_last hold stable until m_ready=1.
  - Pop occurs on m_valid&m_ready.
  - A simultaneous push and pop leaves the count unchanged.
- Throughput with m_ready tied high:
  - first m_valid RD_LATENCY+1 cycles after the start edge;
  - then one beat per cycle;
  - finish at cycle length+RD_LATENCY+1 after start.
- Each address is read exactly once per run, in ascending order. Beats are emitted in the same order.
- Widths: issue_idx and beat counter are 9 bits so length=255 terminates without overflow.

Decomposition:
- Shared package fc_stream_pkg:
  - FSM state localparams IDLE=2'd0, RUN=2'd1, FINISH=2'd2;
  - DEPTH function (RD_LATENCY+2);
  - counter width constant (9).
- One sub-module: fc_stream_fifo, a show-ahead synchronous FIFO (DEPTH, DATA_WIDTH) with push/pop/count and async active-low reset. The top handles FSM, credit, read pipe and ReLU.

Test Plan:
- Basic: length=4, base=0x0010, SRAM[0x10..0x13]=5,-3,7,-1, relu_en=0, m_ready=1 → beats 5,-3,7,-1; m_last on 4th only; rden addrs 0x10..0x13 once each; one finish pulse.
- ReLU: same data, relu_en=1 → beats 5,0,7,0.
- Backpressure: length=8, m_ready pattern 1,0,0,1,0,1,... with RD_LATENCY=1 and 3 → all 8 words in order, each exactly once; data/last stable while stalled; fifo_count+inflight never exceeds DEPTH.
- Zero length: start with length=0 → no rden, m_valid never high, finish high exactly one cycle, then IDLE.
- Reset mid-run: assert rst=0 after 2 beats of a length=6 run → all outputs 0 immediately, no finish. Then start length=3 from base 0x20 → 3 correct beats and finish.
- Wrap and ignore: length=255, base=0xFFF0, second start pulsed mid-run → addresses wrap 0xFFFF→0x0000; second start ignored; 255 beats; one finish.

Source files
------------

// File: rtl/fc_stream_pkg.sv
// rtl/fc_stream_pkg.sv - shared FSM states and sizing helpers for the FC result streamer
package fc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Wide enough that a 255-word job counts to 255 without wrapping.
    localparam int CNT_W = 9;

    // FIFO depth: one slot per in-flight read plus two for full-rate streaming.
    function automatic int fifo_depth(input int rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/fc_result_streamer_if.sv
// rtl/fc_result_streamer_if.sv - valid/ready beat stream towards activation or host DMA
interface fc_result_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fc_stream_fifo.sv
// rtl/fc_stream_fifo.sv - show-ahead FIFO holding words returned by the output SRAM
module fc_stream_fifo #(
    parameter  int DEPTH      = 3,
    parameter  int DATA_WIDTH = 32,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fc_result_streamer.sv
// rtl/fc_result_streamer.sv - streams a finished FC result vector out of the output SRAM
module fc_result_streamer
    import fc_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  finish,
    input  logic [7:0]            length,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  relu_en,
    output logic                  sram_result_rden,
    output logic [ADDR_WIDTH-1:0] sram_result_addr,
    input  logic [DATA_WIDTH-1:0] sram_result_rdata,
    fc_result_streamer_if.master  m_stream
);
    localparam int DEPTH = fifo_depth(RD_LATENCY);
    localparam int CW    = $clog2(DEPTH + 1);

    state_t                  state;
    logic [7:0]              len_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    relu_q;
    logic [CNT_W-1:0]        issue_idx;
    logic [CNT_W-1:0]        beat_cnt;
    logic [RD_LATENCY-1:0]   inflight;
    logic [CW-1:0]           fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [DATA_WIDTH-1:0]   push_data;
    logic [3:0]              occupancy;
    logic                    credit_ok;
    logic                    push;
    logic                    pop;
    logic                    m_valid_w;
    logic                    last_beat;

    // Credit: words already in the FIFO plus reads still in the SRAM pipe.
    always_comb begin
        occupancy = 4'(fifo_count);
        for (int i = 0; i < RD_LATENCY; i++) begin
            occupancy = occupancy + 4'(inflight[i]);
        end
        credit_ok = occupancy < 4'(DEPTH);
    end

    assign sram_result_rden = (state == RUN) && (issue_idx < CNT_W'(len_q)) && credit_ok;
    assign sram_result_addr = sram_result_rden ? base_q + ADDR_WIDTH'(issue_idx) : '0;

    assign push      = inflight[RD_LATENCY-1];
    assign push_data = (relu_q && sram_result_rdata[DATA_WIDTH-1]) ? '0 : sram_result_rdata;

    assign m_valid_w = (fifo_count != '0);
    assign pop       = m_valid_w && m_stream.m_ready;
    assign last_beat = (beat_cnt == CNT_W'(len_q) - 1'b1);

    assign m_stream.m_valid = m_valid_w;
    assign m_stream.m_data  = m_valid_w ? fifo_head : '0;
    assign m_stream.m_last  = m_valid_w && last_beat;
    assign finish           = (state == FINISH);

    // Read pipe: marks the cycle each issued read returns its data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            inflight <= RD_LATENCY'({inflight, sram_result_rden});
        end
    end

    // Control FSM: latch the job on start, count issued reads and delivered beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            base_q    <= '0;
            relu_q    <= 1'b0;
            issue_idx <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= length;
                        base_q    <= base_addr;
                        relu_q    <= relu_en;
                        issue_idx <= '0;
                        beat_cnt  <= '0;
                        state     <= (length == 8'd0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (sram_result_rden) begin
                        issue_idx <= issue_idx + 1'b1;
                    end
                    if (pop) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    fc_stream_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fc_result_streamer.sv
// tb/tb_fc_result_streamer.sv - randomized self-checking bench for fc_result_streamer at read latencies 1 and 3
module tb_fc_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  length;
    logic [15:0] base_addr;
    logic        relu_en;
    logic        m_ready;

    logic [31:0] mem [65536];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rdy_mode = 0;
    int          rdy_k    = 0;
    logic [5:0]  pat      = 6'b101001;

    always #5 clk = ~clk;

    task automatic chk(input int lat, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL [lat=%0d] %s: got %0h expected %0h", lat, name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int LAT = (g == 0) ? 1 : 3;

        fc_result_streamer_if #(.DATA_WIDTH(32)) s_if ();
        logic        rden;
        logic [15:0] addr;
        logic [31:0] rdata;
        logic        finish;

        assign s_if.m_ready = m_ready;

        fc_result_streamer #(
            .ADDR_WIDTH (16),
            .DATA_WIDTH (32),
            .RD_LATENCY (LAT)
        ) dut (
            .clk               (clk),
            .rst               (rst),
            .start             (start),
            .finish            (finish),
            .length            (length),
            .base_addr         (base_addr),
            .relu_en           (relu_en),
            .sram_result_rden  (rden),
            .sram_result_addr  (addr),
            .sram_result_rdata (rdata),
            .m_stream          (s_if.master)
        );

        // SRAM: data for a read appears LAT cycles after its rden, junk otherwise.
        logic [LAT-1:0] sv = '0;
        logic [15:0]    sa [LAT];
        always @(posedge clk) begin
            sv[0] <= rden;
            sa[0] <= addr;
            for (int i = 1; i < LAT; i++) begin
                sv[i] <= sv[i-1];
                sa[i] <= sa[i-1];
            end
        end
        assign rdata = sv[LAT-1] ? mem[sa[LAT-1]] : 32'hDEAD_BEEF;

        int          cyc = 0, busy = 0, fin_exp = 0, issued = 0, popped = 0, mlen = 0;
        int          fin_count = 0, start_cyc = 0, first_lat = -1, fin_lat = -1;
        logic [15:0] mbase;
        logic [31:0] exp_q [$];
        logic [31:0] log_q [$];
        logic        pv = 1'b0;
        logic [31:0] pd;
        logic        pl;

        // Reference model and per-cycle compare.
        initial begin
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst) begin
                    chk(LAT, "rst_rden", rden, 0);
                    chk(LAT, "rst_addr", addr, 0);
                    chk(LAT, "rst_valid", s_if.m_valid, 0);
                    chk(LAT, "rst_data", s_if.m_data, 0);
                    chk(LAT, "rst_last", s_if.m_last, 0);
                    chk(LAT, "rst_finish", finish, 0);
                    busy = 0; fin_exp = 0; pv = 1'b0;
                end else begin
                    automatic int in_fin = fin_exp;
                    automatic int was_idle = (busy == 0) && (fin_exp == 0);
                    chk(LAT, "finish", finish, 64'(fin_exp));
                    if (finish) begin
                        fin_count++;
                        fin_lat = cyc - start_cyc;
                    end
                    fin_exp = 0;
                    if (busy != 0) begin
                        if (rden) begin
                            chk(LAT, "rd_addr", addr, 64'(16'(mbase + 16'(issued))));
                            chk(LAT, "rd_in_range", 64'(issued < mlen), 1);
                            chk(LAT, "rd_credit", 64'((issued - popped) < LAT + 2), 1);
                            issued++;
                        end else begin
                            chk(LAT, "addr_idle", addr, 0);
                        end
                        if (pv) begin
                            chk(LAT, "stall_valid", s_if.m_valid, 1);
                            chk(LAT, "stall_data", s_if.m_data, pd);
                            chk(LAT, "stall_last", s_if.m_last, pl);
                        end
                        if (s_if.m_valid) begin
                            if (first_lat < 0) first_lat = cyc - start_cyc;
                            chk(LAT, "beat_in_range", 64'(popped < mlen), 1);
                            if (popped < mlen) begin
                                chk(LAT, "beat_data", s_if.m_data, exp_q[popped]);
                                chk(LAT, "beat_last", s_if.m_last, 64'(popped == mlen - 1));
                            end
                            if (m_ready) begin
                                log_q.push_back(s_if.m_data);
                                popped++;
                                if (popped == mlen) begin
                                    busy = 0;
                                    fin_exp = 1;
                                end
                            end
                        end
                        pv = s_if.m_valid && !m_ready;
                        pd = s_if.m_data;
                        pl = s_if.m_last;
                    end else begin
                        chk(LAT, "quiet_rden", rden, 0);
                        chk(LAT, "quiet_valid", s_if.m_valid, 0);
                        pv = 1'b0;
                    end
                    if (was_idle != 0 && in_fin == 0 && start) begin
                        mlen = int'(length);
                        mbase = base_addr;
                        exp_q.delete();
                        log_q.delete();
                        for (int i = 0; i < mlen; i++) begin
                            automatic logic [31:0] w = mem[16'(base_addr + 16'(i))];
                            exp_q.push_back((relu_en && w[31]) ? 32'd0 : w);
                        end
                        issued = 0; popped = 0;
                        start_cyc = cyc + 1;
                        first_lat = -1; fin_lat = -1;
                        if (mlen == 0) fin_exp = 1;
                        else busy = 1;
                    end
                end
            end
        end
    end

    // Downstream ready: always high, or a fixed 1,0,0,1,0,1 opening then random.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_ready = 1'b1;
            else begin
                m_ready = (rdy_k < 6) ? pat[rdy_k] : 1'($urandom_range(0, 1));
                rdy_k++;
            end
        end
    end

    task automatic pulse_start(input int len, input logic [15:0] base, input logic relu);
        @(posedge clk);
        #1;
        start = 1'b1; length = 8'(len); base_addr = base; relu_en = relu; rdy_k = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input int len, input logic [15:0] base, input logic relu, input int mode);
        automatic int f0 = g_lat[0].fin_count;
        automatic int f1 = g_lat[1].fin_count;
        rdy_mode = mode;
        pulse_start(len, base, relu);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (g_lat[0].fin_count > f0 && g_lat[1].fin_count > f1) break;
        end
        repeat (3) @(posedge clk);
        chk(1, "finish_once", 64'(g_lat[0].fin_count), 64'(f0 + 1));
        chk(3, "finish_once", 64'(g_lat[1].fin_count), 64'(f1 + 1));
        chk(1, "beat_count", 64'(g_lat[0].log_q.size()), 64'(len));
        chk(3, "beat_count", 64'(g_lat[1].log_q.size()), 64'(len));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; length = '0; base_addr = '0; relu_en = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[16'h10] = 32'd5; mem[16'h11] = 32'hFFFF_FFFD;
        mem[16'h12] = 32'd7; mem[16'h13] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run(4, 16'h0010, 1'b0, 0);
        chk(1, "basic_b0", g_lat[0].log_q[0], 32'd5);
        chk(1, "basic_b1", g_lat[0].log_q[1], 32'hFFFF_FFFD);
        chk(1, "basic_b2", g_lat[0].log_q[2], 32'd7);
        chk(1, "basic_b3", g_lat[0].log_q[3], 32'hFFFF_FFFF);
        chk(3, "basic_b3", g_lat[1].log_q[3], 32'hFFFF_FFFF);
        chk(1, "first_valid_lat", 64'(g_lat[0].first_lat), 2);
        chk(3, "first_valid_lat", 64'(g_lat[1].first_lat), 4);
        chk(1, "finish_lat", 64'(g_lat[0].fin_lat), 6);
        chk(3, "finish_lat", 64'(g_lat[1].fin_lat), 8);

        run(4, 16'h0010, 1'b1, 0);
        chk(1, "relu_b1", g_lat[0].log_q[1], 32'd0);
        chk(1, "relu_b2", g_lat[0].log_q[2], 32'd7);
        chk(3, "relu_b3", g_lat[1].log_q[3], 32'd0);
        chk(3, "relu_b0", g_lat[1].log_q[0], 32'd5);

        run(8, 16'($urandom), 1'b0, 1);
        run(8, 16'($urandom), 1'b1, 1);
        run(0, 16'h0040, 1'b0, 0);

        begin
            automatic int f0 = g_lat[0].fin_count;
            automatic int f1 = g_lat[1].fin_count;
            rdy_mode = 0;
            pulse_start(6, 16'h0300, 1'b0);
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (g_lat[0].log_q.size() >= 2) break;
            end
            chk(1, "two_beats_before_reset", 64'(g_lat[0].log_q.size() >= 2), 1);
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            repeat (4) @(posedge clk);
            chk(1, "no_finish_after_reset", 64'(g_lat[0].fin_count), 64'(f0));
            chk(3, "no_finish_after_reset", 64'(g_lat[1].fin_count), 64'(f1));
        end
        run(3, 16'h0020, 1'b0, 0);

        begin
            automatic int f0 = g_lat[0].fin_count;
            automatic int f1 = g_lat[1].fin_count;
            rdy_mode = 1;
            pulse_start(255, 16'hFFF0, 1'b1);
            repeat (50) @(posedge clk);
            pulse_start(5, 16'h1234, 1'b0);
            for (int c = 0; c < 5000; c++) begin
                @(posedge clk);
                if (g_lat[0].fin_count > f0 && g_lat[1].fin_count > f1) break;
            end
            repeat (10) @(posedge clk);
            chk(1, "wrap_finish_once", 64'(g_lat[0].fin_count), 64'(f0 + 1));
            chk(3, "wrap_finish_once", 64'(g_lat[1].fin_count), 64'(f1 + 1));
            chk(1, "wrap_beats", 64'(g_lat[0].log_q.size()), 255);
            chk(3, "wrap_beats", 64'(g_lat[1].log_q.size()), 255);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
